aes_coprocessor: RTL and testbench

- Memory-mapped AES-128 ECB coprocessor on the CPU data bus at base 0x0004_0000.
- Holds a 256-word input buffer, a 256-word output buffer, a key register and control/length registers.
- On command, it streams LEN 128-bit blocks from the input buffer through the team's iterative aes128_core (encrypt or decrypt) into the output buffer, then sets a sticky DONE flag for the CPU to poll.

---
 rtl/aes_coprocessor_if.sv | 26 ++
 rtl/aes_coprocessor.sv | 399 +++++++++++++++++++++++++++++++++++++++
 tb/tb_aes_coprocessor.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/aes_coprocessor_if.sv
// CPU data-bus bundle for the AES coprocessor.
//   cpu_addr_in          byte address driven by the CPU
//   cpu_data_in          write data driven by the CPU
//   cpu_write_enable_in  per-byte write enables, all-zero means a read
//   cpu_data_out         registered read data returned by the coprocessor
// The master modport is the CPU side and the slave modport is the coprocessor side.
interface aes_coprocessor_if;
  logic [31:0] cpu_addr_in;
  logic [31:0] cpu_data_in;
  logic [3:0]  cpu_write_enable_in;
  logic [31:0] cpu_data_out;

  modport master (
    output cpu_addr_in,
    output cpu_data_in,
    output cpu_write_enable_in,
    input  cpu_data_out
  );

  modport slave (
    input  cpu_addr_in,
    input  cpu_data_in,
    input  cpu_write_enable_in,
    output cpu_data_out
  );
endinterface

// File: rtl/aes_coprocessor.sv
// Memory-mapped AES-128 ECB coprocessor plus the iterative aes128_core it drives.
//
// aes128_core ports:
//   clk, rst            clock and asynchronous active-high reset
//   start               1-cycle pulse that launches one block
//   decrypt             1 = decrypt, 0 = encrypt (sampled with start)
//   key                 128-bit cipher key (held stable while running)
//   block_in            128-bit input block (sampled with start)
//   block_out           128-bit result, valid together with done
//   done                1-cycle pulse when block_out is ready
//
// aes_coprocessor ports:
//   clk_in              system clock, rising edge
//   rst_in              asynchronous active-high reset, aborts any run
//   cpu                 CPU bus (aes_coprocessor_if.slave)
module aes128_core (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         decrypt,
  input  logic [127:0] key,
  input  logic [127:0] block_in,
  output logic [127:0] block_out,
  output logic         done
);
  typedef enum logic [1:0] {C_IDLE, C_ENC, C_KEYFWD, C_DEC} coreState_e;

  coreState_e   state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] rk_q, rk_d, data_q, data_d, fwdKey, invKey;
  logic         done_q, done_d;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; zero maps to zero as AES requires.
  function automatic logic [7:0] gfInv(input logic [7:0] a);
    logic [7:0] p, r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  // S-boxes are computed rather than tabulated to keep the source compact.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] i;
    i = gfInv(a);
    return i ^ rotl(i, 1) ^ rotl(i, 2) ^ rotl(i, 3) ^ rotl(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] invSbox(input logic [7:0] a);
    return gfInv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] subRotWord(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] expandKey(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ subRotWord(k[31:0]) ^ {rc, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Walks the key schedule backwards so decryption needs no round-key storage.
  function automatic logic [127:0] invExpandKey(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ subRotWord(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  // Byte (c,r) of the state lives at bits [127-8*(4c+r) -: 8].
  function automatic logic [127:0] encRound(input logic [127:0] s, input logic lastRound);
    logic [127:0] t;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
    if (!lastRound) begin
      for (int c = 0; c < 4; c++) begin
        {a0, a1, a2, a3} = t[127-32*c -: 32];
        t[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                             xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      end
    end
    return t;
  endfunction

  function automatic logic [127:0] decRound(input logic [127:0] s, input logic [127:0] k,
                                            input logic mixCols);
    logic [127:0] t;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127-8*(4*c+r) -: 8] = invSbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
    t ^= k;
    if (mixCols) begin
      for (int c = 0; c < 4; c++) begin
        {a0, a1, a2, a3} = t[127-32*c -: 32];
        t[127-32*c -: 32] = {
          gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
          gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
          gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
          gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
      end
    end
    return t;
  endfunction

  assign fwdKey    = expandKey(rk_q, rcon(round_q));
  assign invKey    = invExpandKey(rk_q, rcon(round_q));
  assign block_out = data_q;
  assign done      = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= C_IDLE;
      round_q <= 4'd0;
      rk_q    <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      rk_q    <= rk_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  // One round per cycle. Decryption first runs the schedule forward to K10,
  // then applies rounds while stepping the schedule back down to K0.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    rk_d    = rk_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      C_IDLE: begin
        if (start) begin
          rk_d    = key;
          round_d = 4'd1;
          if (decrypt) begin
            data_d  = block_in;
            state_d = C_KEYFWD;
          end else begin
            data_d  = block_in ^ key;
            state_d = C_ENC;
          end
        end
      end
      C_ENC: begin
        rk_d   = fwdKey;
        data_d = encRound(data_q, round_q == 4'd10) ^ fwdKey;
        if (round_q == 4'd10) begin
          done_d  = 1'b1;
          state_d = C_IDLE;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      C_KEYFWD: begin
        rk_d = fwdKey;
        if (round_q == 4'd10) begin
          data_d  = data_q ^ fwdKey;
          state_d = C_DEC;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      C_DEC: begin
        rk_d   = invKey;
        data_d = decRound(data_q, invKey, round_q != 4'd1);
        if (round_q == 4'd1) begin
          done_d  = 1'b1;
          state_d = C_IDLE;
        end else begin
          round_d = round_q - 4'd1;
        end
      end
      default: state_d = C_IDLE;
    endcase
  end
endmodule

module aes_coprocessor #(
  parameter int BUF_WORDS   = 256,
  parameter int DEFAULT_LEN = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  aes_coprocessor_if.slave  cpu
);
  localparam int IDXW = $clog2(BUF_WORDS);
  localparam int BLKW = IDXW - 2;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_WAIT, S_STORE, S_NEXT, S_FIN} state_e;

  logic [31:0]     inBuf  [BUF_WORDS];
  logic [31:0]     outBuf [BUF_WORDS];
  state_e          state_q, state_d;
  logic [7:0]      blkCnt_q, blkCnt_d;
  logic [1:0]      wordCnt_q, wordCnt_d;
  logic [127:0]    block_q, block_d;
  logic            decrypt_q, decrypt_d, done_q, done_d;
  logic [7:0]      len_q;
  logic [127:0]    key_q;
  logic [31:0]     rdata_q, readMux;
  logic            inRegion, hitIn, hitOut, hitCtrl, hitLen, hitKey;
  logic            busy, cpuWrite, cfgWrite, startReq, coreStart, coreDone;
  logic [1:0]      keySel;
  logic [IDXW-1:0] cpuIdx, memIdx;
  logic [127:0]    coreOut;
  logic            unusedAddrBits;

  assign inRegion       = cpu.cpu_addr_in[31:16] == 16'h0004;
  assign hitIn          = inRegion && cpu.cpu_addr_in[15:10] == 6'd0;
  assign hitOut         = inRegion && cpu.cpu_addr_in[15:10] == 6'd1;
  assign hitCtrl        = inRegion && cpu.cpu_addr_in[15:2] == 14'h3C00;
  assign hitLen         = inRegion && cpu.cpu_addr_in[15:2] == 14'h3C01;
  assign hitKey         = inRegion && cpu.cpu_addr_in[15:4] == 12'hF01;
  assign keySel         = cpu.cpu_addr_in[3:2];
  assign cpuIdx         = cpu.cpu_addr_in[IDXW+1:2];
  assign unusedAddrBits = ^cpu.cpu_addr_in[1:0];
  assign memIdx         = {blkCnt_q[BLKW-1:0], wordCnt_q};
  assign busy           = state_q != S_IDLE;
  assign cpuWrite       = |cpu.cpu_write_enable_in;
  assign cfgWrite       = cpuWrite && !busy;
  // XOR enforces "exactly one of ENC/DEC"; both or neither is ignored.
  assign startReq       = cfgWrite && hitCtrl && cpu.cpu_write_enable_in[0] &&
                          (cpu.cpu_data_in[0] ^ cpu.cpu_data_in[1]);
  assign cpu.cpu_data_out = rdata_q;

  aes128_core uCore (
    .clk       (clk_in),
    .rst       (rst_in),
    .start     (coreStart),
    .decrypt   (decrypt_q),
    .key       (key_q),
    .block_in  (block_q),
    .block_out (coreOut),
    .done      (coreDone)
  );

  // Buffers carry no reset; the FSM owns the output buffer while busy.
  always_ff @(posedge clk_in) begin
    if (state_q == S_STORE) begin
      outBuf[memIdx] <= block_q[32*(3-int'(wordCnt_q)) +: 32];
    end else if (cfgWrite && hitOut) begin
      for (int b = 0; b < 4; b++)
        if (cpu.cpu_write_enable_in[b]) outBuf[cpuIdx][8*b +: 8] <= cpu.cpu_data_in[8*b +: 8];
    end
    if (cfgWrite && hitIn) begin
      for (int b = 0; b < 4; b++)
        if (cpu.cpu_write_enable_in[b]) inBuf[cpuIdx][8*b +: 8] <= cpu.cpu_data_in[8*b +: 8];
    end
  end

  // LEN and KEY are frozen while a run is in progress.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      len_q <= DEFAULT_LEN[7:0];
      key_q <= 128'h000102030405060708090a0b0c0d0e0f;
    end else if (cfgWrite) begin
      if (hitLen && cpu.cpu_write_enable_in[0]) len_q <= cpu.cpu_data_in[7:0];
      if (hitKey) begin
        for (int b = 0; b < 4; b++)
          if (cpu.cpu_write_enable_in[b])
            key_q[32*(3-int'(keySel)) + 8*b +: 8] <= cpu.cpu_data_in[8*b +: 8];
      end
    end
  end

  // Buffer reads are blanked while busy so the CPU never sees half-finished data.
  always_comb begin
    readMux = '0;
    if (hitCtrl)              readMux = {28'd0, busy, done_q, 2'b00};
    else if (hitLen)          readMux = {24'd0, len_q};
    else if (hitKey)          readMux = key_q[32*(3-int'(keySel)) +: 32];
    else if (hitIn && !busy)  readMux = inBuf[cpuIdx];
    else if (hitOut && !busy) readMux = outBuf[cpuIdx];
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rdata_q   <= '0;
      state_q   <= S_IDLE;
      blkCnt_q  <= 8'd0;
      wordCnt_q <= 2'd0;
      block_q   <= '0;
      decrypt_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (!cpuWrite) rdata_q <= readMux;
      state_q   <= state_d;
      blkCnt_q  <= blkCnt_d;
      wordCnt_q <= wordCnt_d;
      block_q   <= block_d;
      decrypt_q <= decrypt_d;
      done_q    <= done_d;
    end
  end

  // Sequencer: per block, 4 loads, core start, wait, 4 stores, advance.
  // blkCnt_q counts completed blocks; its low bits double as the wrapping block index.
  always_comb begin
    state_d   = state_q;
    blkCnt_d  = blkCnt_q;
    wordCnt_d = wordCnt_q;
    block_d   = block_q;
    decrypt_d = decrypt_q;
    done_d    = done_q;
    coreStart = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (startReq) begin
          decrypt_d = cpu.cpu_data_in[1];
          done_d    = 1'b0;
          blkCnt_d  = 8'd0;
          wordCnt_d = 2'd0;
          state_d   = (len_q == 8'd0) ? S_FIN : S_LOAD;
        end
      end
      S_LOAD: begin
        block_d[32*(3-int'(wordCnt_q)) +: 32] = inBuf[memIdx];
        wordCnt_d = wordCnt_q + 2'd1;
        if (wordCnt_q == 2'd3) state_d = S_RUN;
      end
      S_RUN: begin
        coreStart = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (coreDone) begin
          block_d = coreOut;
          state_d = S_STORE;
        end
      end
      S_STORE: begin
        wordCnt_d = wordCnt_q + 2'd1;
        if (wordCnt_q == 2'd3) state_d = S_NEXT;
      end
      S_NEXT: begin
        blkCnt_d = blkCnt_q + 8'd1;
        state_d  = (blkCnt_q + 8'd1 == len_q) ? S_FIN : S_LOAD;
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_aes_coprocessor.sv
// Self-checking bench for aes_coprocessor. Reads push their expected word into
// a scoreboard queue; a monitor pops and compares when the registered read
// data becomes valid one cycle later.
module tb_aes_coprocessor;
  localparam logic [31:0] CTRL = 32'h0004_F000;
  localparam logic [31:0] LEN  = 32'h0004_F004;
  localparam logic [31:0] KEY0 = 32'h0004_F010;
  localparam logic [31:0] KEY3 = 32'h0004_F01C;
  localparam logic [31:0] INB  = 32'h0004_0000;
  localparam logic [31:0] OUTB = 32'h0004_0400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdIssue = 1'b0;
  logic rdValid = 1'b0;
  int   checkCount = 0;
  int   passCount = 0;
  logic [31:0] expQ[$];
  string       tagQ[$];

  logic [31:0] ptWords [8] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff,
                               32'h6b2ee973, 32'hc1403d93, 32'hbe9f7e17, 32'h22a4f7d2};
  logic [31:0] ctWords [4] = '{32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};
  logic [31:0] fillWords [8] = '{32'h6b2ee973, 32'hc1403d93, 32'hbe9f7e17, 32'h22a4f7d2,
                                 32'h2e409f96, 32'he93d7e11, 32'h7393172a, 32'h579cac51};

  aes_coprocessor_if cpuBus ();

  aes_coprocessor #(.BUF_WORDS(256), .DEFAULT_LEN(2)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .cpu    (cpuBus.slave)
  );

  always #5 clk = ~clk;

  // Marks the cycle in which the DUT captured a scoreboarded read address.
  always @(posedge clk) rdValid <= rdIssue;

  task automatic compareWord(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %08h, expected %08h", tag, got, exp);
  endtask

  // Monitor: pops the scoreboard whenever registered read data is valid.
  always @(negedge clk) begin
    if (rdValid) begin
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpectedRead: got %08h, expected no read", cpuBus.cpu_data_out);
      end else begin
        compareWord(tagQ.pop_front(), cpuBus.cpu_data_out, expQ.pop_front());
      end
    end
  end

  // One bus write cycle; called at a negedge, returns at the next negedge.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] be = 4'hf);
    cpuBus.cpu_addr_in = addr;
    cpuBus.cpu_data_in = data;
    cpuBus.cpu_write_enable_in = be;
    rdIssue = 1'b0;
    @(negedge clk);
    cpuBus.cpu_write_enable_in = 4'h0;
  endtask

  // One scoreboarded read cycle.
  task automatic checkOutput(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    cpuBus.cpu_addr_in = addr;
    cpuBus.cpu_write_enable_in = 4'h0;
    expQ.push_back(exp);
    tagQ.push_back(tag);
    rdIssue = 1'b1;
    @(negedge clk);
    rdIssue = 1'b0;
  endtask

  // Unchecked read used for polling and copying.
  task automatic rawRead(input logic [31:0] addr, output logic [31:0] data);
    cpuBus.cpu_addr_in = addr;
    cpuBus.cpu_write_enable_in = 4'h0;
    rdIssue = 1'b0;
    @(negedge clk);
    data = cpuBus.cpu_data_out;
  endtask

  task automatic waitDone(input int maxCycles, input string tag);
    logic [31:0] v;
    int n = 0;
    v = '0;
    while (!v[2] && n < maxCycles) begin
      rawRead(CTRL, v);
      n++;
    end
    checkCount++;
    if (v[2]) passCount++;
    else $display("[TB] FAIL %s: DONE not seen after %0d cycles, ctrl %08h", tag, n, v);
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] w;
    cpuBus.cpu_addr_in = '0;
    cpuBus.cpu_data_in = '0;
    cpuBus.cpu_write_enable_in = 4'h0;
    repeat (3) @(negedge clk);
    compareWord("resetDataOut", cpuBus.cpu_data_out, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] reset values");
    checkOutput(CTRL, 32'h0, "resetCtrl");
    checkOutput(LEN, 32'h2, "resetLen");
    checkOutput(KEY0, 32'h00010203, "resetKey0");
    checkOutput(KEY3, 32'h0c0d0e0f, "resetKey3");

    $display("[TB] both ENC and DEC written");
    applyStimulus(CTRL, 32'h3);
    checkOutput(CTRL, 32'h0, "bothBitsNoStart");
    repeat (3) @(negedge clk);
    checkOutput(CTRL, 32'h0, "bothBitsStillIdle");

    $display("[TB] buffer write/readback");
    for (int i = 0; i < 7; i++) applyStimulus(INB + 32'(4*i), fillWords[i]);
    applyStimulus(INB + 32'h1D, fillWords[7]);
    applyStimulus(INB + 32'h20, 32'hdeadbeef);
    for (int i = 0; i < 8; i++) checkOutput(INB + 32'(4*i), fillWords[i], $sformatf("inWord%0d", i));
    checkOutput(INB + 32'h1D, fillWords[7], "aliasWord7");
    checkOutput(INB + 32'h20, 32'hdeadbeef, "inWord8");
    applyStimulus(INB + 32'h20, 32'h000000aa, 4'b0001);
    checkOutput(INB + 32'h20, 32'hdeadbeaa, "byteEnable");
    applyStimulus(32'h0005_0000, 32'h12345678);
    checkOutput(32'h0005_0000, 32'h0, "unmappedRead");
    checkOutput(32'h0004_F008, 32'h0, "holeRead");
    checkOutput(INB, fillWords[0], "unmappedNoAlias");

    $display("[TB] single-block encrypt");
    applyStimulus(LEN, 32'h1);
    for (int i = 0; i < 4; i++) applyStimulus(INB + 32'(4*i), ptWords[i]);
    applyStimulus(INB + 32'h24, 32'h11111111);
    applyStimulus(CTRL, 32'h1);
    checkOutput(CTRL, 32'h8, "busyAfterEnc");
    checkOutput(INB, 32'h0, "bufReadWhileBusy");
    applyStimulus(INB + 32'h24, 32'h22222222);
    applyStimulus(KEY0, 32'hffffffff);
    applyStimulus(LEN, 32'h5);
    applyStimulus(CTRL, 32'h1);
    waitDone(200, "encDone");
    checkOutput(CTRL, 32'h4, "ctrlDoneEnc");
    checkOutput(INB + 32'h24, 32'h11111111, "busyWriteDropped");
    checkOutput(KEY0, 32'h00010203, "busyKeyDropped");
    checkOutput(LEN, 32'h1, "busyLenDropped");
    for (int i = 0; i < 4; i++) checkOutput(OUTB + 32'(4*i), ctWords[i], $sformatf("encOut%0d", i));

    $display("[TB] single-block decrypt");
    for (int i = 0; i < 4; i++) applyStimulus(INB + 32'(4*i), ctWords[i]);
    applyStimulus(CTRL, 32'h2);
    checkOutput(CTRL, 32'h8, "busyAfterDec");
    waitDone(200, "decDone");
    for (int i = 0; i < 4; i++) checkOutput(OUTB + 32'(4*i), ptWords[i], $sformatf("decOut%0d", i));

    $display("[TB] two-block round trip with default LEN");
    pulseReset();
    checkOutput(LEN, 32'h2, "lenAfterReset");
    for (int i = 0; i < 8; i++) applyStimulus(INB + 32'(4*i), ptWords[i]);
    applyStimulus(OUTB + 32'h20, 32'hcafef00d);
    applyStimulus(CTRL, 32'h1);
    waitDone(300, "enc2Done");
    for (int i = 0; i < 4; i++) checkOutput(OUTB + 32'(4*i), ctWords[i], $sformatf("enc2Out%0d", i));
    for (int i = 0; i < 8; i++) begin
      rawRead(OUTB + 32'(4*i), w);
      applyStimulus(INB + 32'(4*i), w);
    end
    applyStimulus(CTRL, 32'h2);
    waitDone(300, "dec2Done");
    for (int i = 0; i < 8; i++) checkOutput(OUTB + 32'(4*i), ptWords[i], $sformatf("roundTrip%0d", i));
    checkOutput(OUTB + 32'h20, 32'hcafef00d, "outWord8Untouched");

    $display("[TB] reset mid-run");
    for (int i = 0; i < 8; i++) applyStimulus(OUTB + 32'(4*i), 32'ha5a5a5a5);
    applyStimulus(CTRL, 32'h1);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput(CTRL, 32'h0, "ctrlAfterAbort");
    repeat (60) @(negedge clk);
    checkOutput(CTRL, 32'h0, "ctrlStaysIdle");
    for (int i = 0; i < 8; i++) checkOutput(OUTB + 32'(4*i), 32'ha5a5a5a5, $sformatf("abortOut%0d", i));

    repeat (3) @(negedge clk);
    checkCount++;
    if (expQ.size() == 0) passCount++;
    else $display("[TB] FAIL scoreboardDrain: got %0d pending, expected 0", expQ.size());

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
